// File: rtl/cpu_mc_param.sv
// Parametrised multi-cycle CPU core with IDLE/HALT FSM and req/ack data-memory handshake.
// Optional retired-instruction counter enabled by defining CPU_PERF_CNT_EN.
module cpu_mc_param #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    output logic [ADDR_W-1:0]     imem_addr,
    input  logic [15:0]           imem_rdata,
    output logic [ADDR_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  dmem_req,
    output logic                  dmem_write,
    input  logic                  dmem_ack,
    input  logic                  start,
    input  logic                  stop,
    output logic                  halted,
    output logic [8*DATA_W-1:0]   led_reg,
    output logic [4*DATA_W-1:0]   led_misc,
    output logic [2:0]            led_ph,
    output logic [31:0]           instret
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LI   = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_LD   = 4'h4,
        OP_ST   = 4'h5,
        OP_B    = 4'h6,
        OP_BNZ  = 4'h7,
        OP_HALT = 4'hF
    } opcode_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic [DATA_W-1:0] sr1, sr2, alu_q, dr;
    logic [DATA_W-1:0] regs [8];
`ifdef CPU_PERF_CNT_EN
    logic [31:0]       instret_q;
`endif

    opcode_t           op;
    logic [2:0]        rd, rs1, rs2;
    logic signed [7:0] imm8;
    logic [DATA_W-1:0] imm_d;
    logic [ADDR_W-1:0] imm_a;
    logic [DATA_W-1:0] alu_res;
    logic              taken;

    assign op    = opcode_t'(ir[15:12]);
    assign rd    = ir[11:9];
    assign rs1   = ir[8:6];
    assign rs2   = ir[5:3];
    assign imm8  = ir[7:0];
    assign imm_d = DATA_W'(imm8);
    assign imm_a = ADDR_W'(imm8);

    // PC already holds A+1 after fetch, so the branch target is pc + imm.
    assign taken = (op == OP_B) || ((op == OP_BNZ) && (sr1 != '0));

    always_comb begin
        alu_res = '0;
        case (op)
            OP_LI:   alu_res = imm_d;
            OP_ADD:  alu_res = sr1 + sr2;
            OP_SUB:  alu_res = sr1 - sr2;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc         <= RESET_PC;
            ir         <= '0;
            sr1        <= '0;
            sr2        <= '0;
            alu_q      <= '0;
            dr         <= '0;
            for (int unsigned i = 0; i < 8; i++) regs[i] <= '0;
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_write <= 1'b0;
            halted     <= 1'b0;
`ifdef CPU_PERF_CNT_EN
            instret_q  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stop) state <= FETCH;
                end
                FETCH: begin
                    ir    <= imem_rdata;
                    pc    <= pc + ADDR_W'(1);
                    state <= DECODE;
                end
                DECODE: begin
                    sr1   <= (op == OP_BNZ) ? regs[rd] : regs[rs1];
                    sr2   <= regs[rs2];
                    state <= EXEC;
                end
                EXEC: begin
                    alu_q <= alu_res;
                    case (op)
                        OP_LD, OP_ST: begin
                            dmem_req   <= 1'b1;
                            dmem_write <= (op == OP_ST);
                            state      <= MEM;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= HALT;
`ifdef CPU_PERF_CNT_EN
                            instret_q <= instret_q + 32'd1;
`endif
                        end
                        default: state <= WB;
                    endcase
                end
                MEM: begin
                    // Request and write strobe drop together the cycle after ack.
                    if (dmem_ack) begin
                        if (!dmem_write) dr <= dmem_rdata;
                        dmem_req   <= 1'b0;
                        dmem_write <= 1'b0;
                        state      <= WB;
                    end
                end
                WB: begin
                    case (op)
                        OP_LI, OP_ADD, OP_SUB: regs[rd] <= alu_q;
                        OP_LD:                 regs[rd] <= dr;
                        default: ;
                    endcase
                    if (taken) pc <= pc + imm_a;
`ifdef CPU_PERF_CNT_EN
                    instret_q <= instret_q + 32'd1;
`endif
                    state <= stop ? IDLE : FETCH;
                end
                HALT: begin
                    if (start) begin
                        halted <= 1'b0;
                        state  <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign imem_addr  = pc;
    assign dmem_addr  = ADDR_W'(sr1);
    assign dmem_wdata = sr2;
    assign led_ph     = state;
    assign led_misc   = {alu_q, sr2, sr1, DATA_W'(ir)};

    always_comb begin
        led_reg = '0;
        for (int unsigned i = 0; i < 8; i++) led_reg[i*DATA_W +: DATA_W] = regs[i];
    end

`ifdef CPU_PERF_CNT_EN
    assign instret = instret_q;
`else
    assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_mc_param.sv
// Directed self-checking bench for cpu_mc_param: a 16-bit core running a small program
// plus an 8-bit core checking arithmetic wrap and a non-zero reset vector.
module tb_cpu_mc_param;

`ifdef CPU_PERF_CNT_EN
    localparam int unsigned PERF = 1;
`else
    localparam int unsigned PERF = 0;
`endif

    logic         CLK = 1'b0;
    logic         RST, start, stop;
    always #5 CLK = ~CLK;

    // 16-bit core
    logic [15:0]  imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic         dmem_req, dmem_write, dmem_ack, halted;
    logic [127:0] led_reg;
    logic [63:0]  led_misc;
    logic [2:0]   led_ph;
    logic [31:0]  instret;

    // 8-bit core
    logic [7:0]   imem_addr8, dmem_addr8, dmem_wdata8;
    logic [15:0]  imem_rdata8;
    logic         dmem_req8, dmem_write8, halted8;
    logic [63:0]  led_reg8;
    logic [31:0]  led_misc8;
    logic [2:0]   led_ph8;
    logic [31:0]  instret8;

    logic [15:0]  imem  [0:255];
    logic [15:0]  imem8 [0:255];
    logic [15:0]  dmem  [0:255];
    int           wcnt, wait_cfg;
    logic         ack_en;
    int           vectors, miscompares;
    int           req_cyc, unstable;

    cpu_mc_param #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .CLK(CLK), .RST(RST), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_req(dmem_req), .dmem_write(dmem_write), .dmem_ack(dmem_ack),
        .start(start), .stop(stop), .halted(halted), .led_reg(led_reg),
        .led_misc(led_misc), .led_ph(led_ph), .instret(instret)
    );

    cpu_mc_param #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'h20)) dut8 (
        .CLK(CLK), .RST(RST), .imem_addr(imem_addr8), .imem_rdata(imem_rdata8),
        .dmem_addr(dmem_addr8), .dmem_wdata(dmem_wdata8), .dmem_rdata(8'h00),
        .dmem_req(dmem_req8), .dmem_write(dmem_write8), .dmem_ack(1'b0),
        .start(start), .stop(stop), .halted(halted8), .led_reg(led_reg8),
        .led_misc(led_misc8), .led_ph(led_ph8), .instret(instret8)
    );

    assign imem_rdata  = imem[imem_addr[7:0]];
    assign imem_rdata8 = imem8[imem_addr8];
    assign dmem_rdata  = dmem[dmem_addr[7:0]];
    assign dmem_ack    = dmem_req && ack_en && (wcnt == wait_cfg);

    // Data memory with wait_cfg wait states before ack.
    always @(posedge CLK) begin
        if (!dmem_req || dmem_ack) wcnt <= 0;
        else                       wcnt <= wcnt + 1;
        if (dmem_req && dmem_ack && dmem_write) dmem[dmem_addr[7:0]] <= dmem_wdata;
    end

    function automatic logic [15:0] r16(input int unsigned i);
        return led_reg[i*16 +: 16];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Step from FETCH until the core is back in FETCH, IDLE or HALT.
    task automatic run_instr(output int cyc);
        logic [15:0] a0, w0;
        bit          seen;
        cyc = 0; req_cyc = 0; unstable = 0; seen = 0; a0 = '0; w0 = '0;
        do begin
            @(posedge CLK); #1;
            cyc++;
            if (dmem_req) begin
                if (!seen) begin
                    a0 = dmem_addr; w0 = dmem_wdata; seen = 1;
                end else if (dmem_addr != a0 || dmem_wdata != w0) begin
                    unstable++;
                end
                req_cyc++;
            end
        end while (!(led_ph inside {3'd0, 3'd1, 3'd6}) && cyc < 60);
        if (cyc >= 60) check("instr_timeout", 64'(cyc), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        vectors = 0; miscompares = 0;
        for (int i = 0; i < 256; i++) begin
            imem[i] = 16'h0000; imem8[i] = 16'h0000; dmem[i] = 16'h0000;
        end
        imem[8'h00] = 16'h1205;  // LI  r1,5
        imem[8'h01] = 16'h14FD;  // LI  r2,-3
        imem[8'h02] = 16'h2650;  // ADD r3,r1,r2
        imem[8'h03] = 16'h5050;  // ST  mem[r1]=r2
        imem[8'h04] = 16'h4A40;  // LD  r5=mem[r1]
        imem[8'h05] = 16'h1C01;  // LI  r6,1
        imem[8'h06] = 16'h1802;  // LI  r4,2
        imem[8'h07] = 16'h3930;  // SUB r4,r4,r6
        imem[8'h08] = 16'h78FE;  // BNZ r4,-2
        imem[8'h09] = 16'h6006;  // B   +6 -> 0x10
        imem[8'h10] = 16'hF000;  // HALT
        imem[8'h11] = 16'h2E48;  // ADD r7,r1,r1
        imem[8'h12] = 16'h50C8;  // ST  mem[r3]=r1
        imem8[8'h20] = 16'h127F; // LI  r1,127
        imem8[8'h21] = 16'h1401; // LI  r2,1
        imem8[8'h22] = 16'h2650; // ADD r3,r1,r2

        RST = 1'b1; start = 1'b0; stop = 1'b0; ack_en = 1'b1; wait_cfg = 0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_state",   64'(led_ph), 64'd0);
        check("rst_halted",  64'(halted), 64'd0);
        check("rst_req",     64'(dmem_req), 64'd0);
        check("rst_pc",      64'(imem_addr), 64'h0);
        check("rst_instret", 64'(instret), 64'd0);
        check("rst_regs",    led_reg[63:0] | led_reg[127:64], 64'd0);
        check("rst_misc",    led_misc, 64'd0);
        check("rst_pc8",     64'(imem_addr8), 64'h20);
        RST = 1'b0;
        @(posedge CLK); #1;
        check("idle_hold", 64'(led_ph), 64'd0);

        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        check("start_fetch", 64'(led_ph), 64'd1);

        run_instr(c); check("li_lat", 64'(c), 64'd4);
        run_instr(c);
        run_instr(c); check("add_lat", 64'(c), 64'd4);
        check("add_r3",      64'(r16(3)), 64'h0002);
        check("add_instret", 64'(instret), 64'(PERF * 3));
        check("add_pc",      64'(imem_addr), 64'h3);
        check("wrap8_r3",    64'(led_reg8[3*8 +: 8]), 64'h80);
        check("wrap8_r1",    64'(led_reg8[1*8 +: 8]), 64'h7F);

        wait_cfg = 3;
        run_instr(c);
        check("st_lat",      64'(c), 64'd8);
        check("st_req_cyc",  64'(req_cyc), 64'd4);
        check("st_stable",   64'(unstable), 64'd0);
        check("st_mem",      64'(dmem[5]), 64'hFFFD);
        check("st_req_drop", 64'(dmem_req), 64'd0);

        wait_cfg = 0;
        run_instr(c);
        check("ld_lat", 64'(c), 64'd5);
        check("ld_r5",  64'(r16(5)), 64'hFFFD);

        run_instr(c); run_instr(c); run_instr(c);
        run_instr(c);
        check("bnz_lat",   64'(c), 64'd4);
        check("bnz_taken", 64'(imem_addr), 64'h7);
        run_instr(c); run_instr(c);
        check("bnz_exit", 64'(imem_addr), 64'h9);
        check("bnz_r4",   64'(r16(4)), 64'h0);
        run_instr(c);
        check("b_target", 64'(imem_addr), 64'h10);

        run_instr(c);
        check("halt_lat",   64'(c), 64'd3);
        check("halt_state", 64'(led_ph), 64'd6);
        check("halt_flag",  64'(halted), 64'd1);
        check("halt_pc",    64'(imem_addr), 64'h11);
        stop = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        stop = 1'b0;
        check("halt_stop_ign", 64'(led_ph), 64'd6);
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        check("resume_state", 64'(led_ph), 64'd1);
        check("resume_pc",    64'(imem_addr), 64'h11);
        check("resume_flag",  64'(halted), 64'd0);

        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("exec_state", 64'(led_ph), 64'd3);
        stop = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("stop_idle",    64'(led_ph), 64'd0);
        check("stop_add_r7",  64'(r16(7)), 64'h000A);
        check("stop_instret", 64'(instret), 64'(PERF * 14));
        start = 1'b1;
        @(posedge CLK); #1;
        check("start_stop_idle", 64'(led_ph), 64'd0);
        stop = 1'b0;
        @(posedge CLK); #1;
        start = 1'b0;
        check("restart_state", 64'(led_ph), 64'd1);
        check("restart_pc",    64'(imem_addr), 64'h12);

        ack_en = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        check("mem_wait_state", 64'(led_ph), 64'd4);
        check("mem_wait_req",   64'(dmem_req), 64'd1);
        check("mem_wait_addr",  64'(dmem_addr), 64'h2);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("abort_req",     64'(dmem_req), 64'd0);
        check("abort_pc",      64'(imem_addr), 64'h0);
        check("abort_state",   64'(led_ph), 64'd0);
        check("abort_nowrite", 64'(dmem[2]), 64'h0);
        check("abort_r1",      64'(r16(1)), 64'h0);
        check("abort_instret", 64'(instret), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
